// File: rtl/mesh_out_arbiter.sv
// Round-robin scheduler for one output direction of a mesh router node.
// Define STALL_CNT_EN to add a saturating stall_cnt output (idle cycles blocked by full_out).
module mesh_out_arbiter #(
  parameter int unsigned pckg_sz   = 40,
  parameter int unsigned NUM_IN    = 4,
  parameter logic [3:0]  id_row    = 4'd0,
  parameter logic [3:0]  id_column = 4'd0,
  parameter int unsigned OUT_DIR   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         pndng_in,
  input  logic [NUM_IN*pckg_sz-1:0] data_in,
  output logic [NUM_IN-1:0]         pop_out,
  input  logic                      full_out,
  output logic                      push_out,
  output logic [pckg_sz-1:0]        data_out,
  output logic [$clog2(NUM_IN)-1:0] grant_idx
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(NUM_IN);

  localparam logic [2:0] DirN     = 3'd0;
  localparam logic [2:0] DirS     = 3'd1;
  localparam logic [2:0] DirE     = 3'd2;
  localparam logic [2:0] DirW     = 3'd3;
  localparam logic [2:0] DirLocal = 3'd4;

  typedef enum logic {StIdle, StXfer} state_e;

  state_e             state_q, state_d;
  logic [pckg_sz-1:0] data_q, data_d;
  logic [IdxW-1:0]    grant_q, grant_d;
  logic [IdxW-1:0]    rr_q, rr_d;
  logic [NUM_IN-1:0]  elig;
  logic [IdxW-1:0]    winner;
  logic               found;
  logic [pckg_sz-1:0] win_pkt;

  function automatic logic [2:0] route(input logic [pckg_sz-1:0] pkt);
    logic [3:0] dr;
    logic [3:0] dc;
    logic       mode;
    dr   = pkt[pckg_sz-9 -: 4];
    dc   = pkt[pckg_sz-13 -: 4];
    mode = pkt[pckg_sz-17];
    if (dr == id_row && dc == id_column) return DirLocal;
    if (!mode) begin
      if (dc > id_column) return DirE;
      if (dc < id_column) return DirW;
      return (dr > id_row) ? DirS : DirN;
    end
    if (dr > id_row) return DirS;
    if (dr < id_row) return DirN;
    return (dc > id_column) ? DirE : DirW;
  endfunction

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      elig[i] = pndng_in[i] && (route(data_in[i*pckg_sz +: pckg_sz]) == 3'(OUT_DIR));
    end
  end

  // First eligible input at or after rr_q, wrapping modulo NUM_IN.
  always_comb begin
    int unsigned     idx;
    logic [IdxW-1:0] cand;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx  = (int'(rr_q) + k) % NUM_IN;
      cand = IdxW'(idx);
      if (!found && elig[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign win_pkt = data_in[int'(winner)*pckg_sz +: pckg_sz];

  logic unused_nxt_jump;
  assign unused_nxt_jump = ^win_pkt[pckg_sz-1 -: 8];

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        if (found && !full_out) begin
          state_d = StXfer;
          data_d  = {id_row, id_column, win_pkt[pckg_sz-9:0]};
          grant_d = winner;
          rr_d    = (winner == IdxW'(NUM_IN - 1)) ? '0 : winner + 1'b1;
        end
      end
      StXfer:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign push_out  = (state_q == StXfer);
  assign data_out  = data_q;
  assign grant_idx = grant_q;

  always_comb begin
    pop_out = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      pop_out[i] = push_out && (grant_q == IdxW'(i));
    end
  end

`ifdef STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == StIdle && found && full_out && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mesh_out_arbiter.sv
// Bench for mesh_out_arbiter (node 1,1, east output): directed scenarios plus a random phase
// checked every cycle against a queue-free route/round-robin reference model.
module tb_mesh_out_arbiter;

  localparam int ROW = 1;
  localparam int COL = 1;
  localparam int DIR = 2;

  logic         clk;
  logic         reset;
  logic [3:0]   pndng_in;
  logic [159:0] data_in;
  logic [3:0]   pop_out;
  logic         full_out;
  logic         push_out;
  logic [39:0]  data_out;
  logic [1:0]   grant_idx;
`ifdef STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  mesh_out_arbiter #(
    .pckg_sz  (40),
    .NUM_IN   (4),
    .id_row   (4'd1),
    .id_column(4'd1),
    .OUT_DIR  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng_in (pndng_in),
    .data_in  (data_in),
    .pop_out  (pop_out),
    .full_out (full_out),
    .push_out (push_out),
    .data_out (data_out),
    .grant_idx(grant_idx)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] mk(input logic [7:0] nxt, input logic [3:0] dr,
                                     input logic [3:0] dc, input logic mode,
                                     input logic [22:0] pay);
    return {nxt, dr, dc, mode, pay};
  endfunction

  // Direction from signed offsets: 0=N 1=S 2=E 3=W 4=LOCAL.
  function automatic int ref_route(input logic [39:0] p);
    int dy;
    int dx;
    dy = int'(p[31:28]) - ROW;
    dx = int'(p[27:24]) - COL;
    if (dx == 0 && dy == 0) return 4;
    if ((!p[23] && dx != 0) || (p[23] && dy == 0)) return (dx > 0) ? 2 : 3;
    return (dy > 0) ? 1 : 0;
  endfunction

  // Reference model: busy = a transfer is being presented this cycle.
  bit          m_busy;
  int          m_rr;
  logic [1:0]  m_grant;
  logic [39:0] m_data;
  int          m_stall;

  always @(posedge clk) begin : model
    int w;
    int c;
    bit any;
    logic [39:0] p;
    any = 1'b0;
    w   = 0;
    for (int k = 0; k < 4; k++) begin
      c = (m_rr + k) % 4;
      if (!any && pndng_in[c] && ref_route(data_in[c*40 +: 40]) == DIR) begin
        any = 1'b1;
        w   = c;
      end
    end
    p = data_in[w*40 +: 40];
    if (reset) begin
      m_busy  <= 1'b0;
      m_rr    <= 0;
      m_grant <= 2'd0;
      m_data  <= 40'd0;
      m_stall <= 0;
    end else if (m_busy) begin
      m_busy <= 1'b0;
    end else if (any && !full_out) begin
      m_busy  <= 1'b1;
      m_grant <= 2'(w);
      m_rr    <= (w + 1) % 4;
      m_data  <= {8'(ROW * 16 + COL), p[31:0]};
    end else if (any && full_out && m_stall < 65535) begin
      m_stall <= m_stall + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("push", 64'(push_out), 64'(m_busy));
      check("pop", 64'(pop_out), m_busy ? 64'(4'b0001 << m_grant) : 64'd0);
      check("data", 64'(data_out), 64'(m_data));
      check("grant", 64'(grant_idx), 64'(m_grant));
`ifdef STALL_CNT_EN
      check("stall", 64'(stall_cnt), 64'(m_stall));
`endif
    end
  end

  int   gq[$];
  int   exp_rr[5] = '{0, 1, 2, 3, 0};
  logic [9:0] pat;
  int   cnt_push;
  int   cnt_pop1;

  initial begin
    reset    = 1'b1;
    pndng_in = 4'b0000;
    data_in  = '0;
    full_out = 1'b0;
    repeat (5) @(negedge clk);
    chk_en = 1'b1;
    check("rst_push", 64'(push_out), 64'd0);
    check("rst_pop", 64'(pop_out), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);

    // Grant input 2, then reset while it is in flight.
    reset = 1'b0;
    data_in[80 +: 40] = mk(8'h00, 4'd1, 4'd2, 1'b0, 23'h012345);
    pndng_in = 4'b0100;
    @(negedge clk);
    check("pre_rst_push", 64'(push_out), 64'd1);
    check("pre_rst_grant", 64'(grant_idx), 64'd2);
    reset = 1'b1;
    pndng_in = 4'b0000;
    @(negedge clk);
    check("xfer_rst_push", 64'(push_out), 64'd0);
    check("xfer_rst_pop", 64'(pop_out), 64'd0);
    check("xfer_rst_data", 64'(data_out), 64'd0);
    check("xfer_rst_grant", 64'(grant_idx), 64'd0);
    repeat (4) @(negedge clk);
    reset = 1'b0;

    // Round robin over four eastbound requesters.
    for (int i = 0; i < 4; i++) data_in[i*40 +: 40] = mk(8'hFF, 4'd1, 4'd2, 1'b0, 23'(i + 7));
    pndng_in = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pat[i] = push_out;
      if (push_out) gq.push_back(int'(grant_idx));
    end
    pndng_in = 4'b0000;
    check("rr_pattern", 64'(pat), 64'h155);
    check("rr_count", 64'(gq.size()), 64'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++) check("rr_seq", 64'(gq[i]), 64'(exp_rr[i]));
    @(negedge clk);

    // Single request and the 2-cycle re-grant.
    data_in[0 +: 40] = mk(8'hA5, 4'd1, 4'd2, 1'b0, 23'h0ABCDE);
    pndng_in = 4'b0001;
    @(negedge clk);
    check("single_push", 64'(push_out), 64'd1);
    check("single_pop", 64'(pop_out), 64'b0001);
    check("single_data", 64'(data_out), 64'({8'h11, 4'h1, 4'h2, 1'b0, 23'h0ABCDE}));
    @(negedge clk);
    check("single_gap", 64'(push_out), 64'd0);
    @(negedge clk);
    check("single_regrant", 64'(push_out), 64'd1);
    pndng_in = 4'b0000;
    @(negedge clk);

    // Westbound input must never be popped.
    data_in[40 +: 40] = mk(8'h00, 4'd1, 4'd0, 1'b0, 23'h055555);
    pndng_in = 4'b0010;
    cnt_push = 0;
    cnt_pop1 = 0;
    repeat (20) begin
      @(negedge clk);
      if (push_out) cnt_push++;
      if (pop_out[1]) cnt_pop1++;
    end
    check("west_push", 64'(cnt_push), 64'd0);
    check("west_pop1", 64'(cnt_pop1), 64'd0);
    pndng_in = 4'b0000;

    // Backpressure.
    data_in[80 +: 40] = mk(8'h00, 4'd3, 4'd4, 1'b0, 23'h077777);
    pndng_in = 4'b0100;
    full_out = 1'b1;
    cnt_push = 0;
    repeat (10) begin
      @(negedge clk);
      if (push_out) cnt_push++;
    end
    check("full_push", 64'(cnt_push), 64'd0);
`ifdef STALL_CNT_EN
    check("stall_10", 64'(stall_cnt), 64'd10);
`endif
    full_out = 1'b0;
    @(negedge clk);
    check("unfull_push", 64'(push_out), 64'd1);
    check("unfull_pop", 64'(pop_out), 64'b0100);
    pndng_in = 4'b0000;
    @(negedge clk);

    // Mode selects row-first (south) versus column-first (east).
    data_in[120 +: 40] = mk(8'h00, 4'd2, 4'd2, 1'b1, 23'h011111);
    pndng_in = 4'b1000;
    cnt_push = 0;
    repeat (4) begin
      @(negedge clk);
      if (push_out) cnt_push++;
    end
    check("mode1_push", 64'(cnt_push), 64'd0);
    data_in[120 +: 40] = mk(8'h00, 4'd2, 4'd2, 1'b0, 23'h011111);
    @(negedge clk);
    check("mode0_push", 64'(push_out), 64'd1);
    check("mode0_pop", 64'(pop_out), 64'b1000);
    pndng_in = 4'b0000;

    // Random traffic, checked every cycle by the compare process.
    repeat (3000) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 199) == 0);
      full_out = ($urandom_range(0, 3) == 0);
      pndng_in = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        data_in[i*40 +: 40] = mk(8'($urandom), 4'($urandom_range(0, 3)),
                                 4'($urandom_range(0, 3)), 1'($urandom), 23'($urandom));
      end
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mesh_out_arbiter.md
Name: mesh_out_arbiter

Overview:
- Per-output-port scheduler for one mesh router node in the mesh_gnrtr array.
- Watches the head packets of NUM_IN input FIFOs (pndng/data) and decodes each header against the node's own coordinates to find its output direction.
- Grants the output FIFO round-robin among inputs whose packet targets OUT_DIR, then issues the pop to the winning input and the push to the output.
- One instance per output direction (N, S, E, W, LOCAL) per node.

Parameters:
- pckg_sz, 40, packet width in bits.
- NUM_IN, 4, number of requesting input FIFOs (2..8).
- id_row, 0, this node's row id (4 bits).
- id_column, 0, this node's column id (4 bits).
- OUT_DIR, 0, output served: 0=N, 1=S, 2=E, 3=W, 4=LOCAL.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pndng_in  in  NUM_IN  input FIFO i non-empty.
- data_in  in  NUM_IN*pckg_sz  head packet of input i, at slice [i*pckg_sz +: pckg_sz].
- pop_out  out  NUM_IN  one-hot pop pulse to input i.
- full_out  in  1  output FIFO full.
- push_out  out  1  push pulse to output FIFO.
- data_out  out  pckg_sz  packet pushed to the output.
- grant_idx  out  $clog2(NUM_IN)  index of the last granted input.

Behaviour:
- Clocking: one clock (clk). reset is synchronous and active-high.
- Header fields:
  - [pckg_sz-1 -: 8] Nxt_jump
  - [pckg_sz-9 -: 4] dest row (dr)
  - [pckg_sz-13 -: 4] dest column (dc)
  - [pckg_sz-17] mode
  - below that: payload.
- Route decode, combinational, per input:
  - LOCAL if dr==id_row and dc==id_column.
  - mode=0 (column first): dc>id_column → E; dc<id_column → W; else dr>id_row → S; dr<id_row → N.
  - mode=1 (row first): rows are compared first, then columns.
- Eligibility: elig[i] = pndng_in[i] & (route_i == OUT_DIR).
- FSM states: IDLE, XFER.
  - IDLE → XFER: when |elig and !full_out. The winner is the first eligible input searching from rr_ptr upward, with wrap-around modulo NUM_IN.
  - On that transition, register the outputs:
    - data_out = data_in[winner], with Nxt_jump replaced by {id_row[3:0], id_column[3:0]}.
    - grant_idx = winner.
    - rr_ptr = (winner+1) mod NUM_IN.
  - XFER: push_out=1 and pop_out=1<<grant_idx for exactly this one cycle; next state is always IDLE.
  - IDLE: push_out=0, pop_out=0.
- Throughput: at most one packet per 2 cycles. The IDLE cycle lets the input FIFO present its new head after the pop.
- Latency: a request visible in cycle n produces push/pop in cycle n+1.
- full_out high in IDLE: stay in IDLE, no grant, rr_ptr unchanged.
- full_out rising during XFER: the push still completes. The decision was made while the FIFO was not full, and the FIFO guarantees one slot.
- pndng_in dropping while in XFER: no effect on the in-flight transfer, since data was already captured.
- Reset, including mid-XFER: state=IDLE, push_out=0, pop_out=0, data_out=0, grant_idx=0, rr_ptr=0. Any pending pulse is dropped.
- An input whose route ≠ OUT_DIR is never popped by this block.

Optional Feature:
- STALL_CNT_EN defined:
  - Adds output stall_cnt, 16 bits.
  - Increments each cycle the FSM is in IDLE with |elig and full_out.
  - Saturates at 16'hFFFF and resets to 0.
- STALL_CNT_EN undefined: no port, no counter logic.

Test Plan:
- Reset check, with id_row=1, id_column=1, OUT_DIR=2 (E), NUM_IN=4. Hold reset 5 cycles, including a reset asserted during an XFER cycle → push_out=0, pop_out=4'b0000, data_out=0, grant_idx=0 on the cycle after reset is sampled.
- Single request: input0 pndng=1 with header dr=1, dc=2, mode=0, payload 23'h0ABCDE → next cycle push_out=1, pop_out=4'b0001, data_out Nxt_jump=8'h11, payload 23'h0ABCDE. Hold pndng: the next grant comes 2 cycles later.
- Direction filter: input1 with dc=0 (westbound) held pending 20 cycles → pop_out[1] never asserted, push_out stays 0.
- Round robin: all four inputs pending and eastbound for 10 cycles → grant_idx sequence 0,1,2,3,0. Push every second cycle.
- Backpressure: full_out=1 for 10 cycles with input2 eastbound → no push. With STALL_CNT_EN, stall_cnt=10. Deassert full_out → push_out=1 and pop_out=4'b0100 in the following cycle.
- Mode: header dr=2, dc=2. mode=1 → routed S, not granted by E arbiter. mode=0 → routed E, granted.
